// File: rtl/pipe_ctrl_multi.sv
// Commit-point pipeline controller for an N-wide core: exception/interrupt/ertn/idle
// arbitration, registered flush and redirect, slot kill and pause. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl_multi #(
    parameter int NUM_STAGES   = 8,
    parameter int ISSUE_WIDTH  = 2,
    parameter int NUM_EXC_SRC  = 6,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_STAGES-1:0]                 pause_req,
    input  logic [ISSUE_WIDTH-1:0]                commit_valid,
    input  logic [ISSUE_WIDTH*32-1:0]             commit_pc,
    input  logic [ISSUE_WIDTH*NUM_EXC_SRC-1:0]    commit_exc,
    input  logic [ISSUE_WIDTH*NUM_EXC_SRC*15-1:0] commit_cause,
    input  logic [ISSUE_WIDTH*32-1:0]             commit_badv,
    input  logic [ISSUE_WIDTH-1:0]                commit_priv,
    input  logic [ISSUE_WIDTH-1:0]                commit_ertn,
    input  logic [ISSUE_WIDTH-1:0]                commit_idle,
    input  logic [1:0]                            csr_plv,
    input  logic                                  csr_ie,
    input  logic [12:0]                           csr_lie,
    input  logic [12:0]                           csr_is,
    input  logic [31:0]                           csr_era,
    input  logic [31:0]                           csr_eentry,
    output logic                                  flush,
    output logic [31:0]                           flush_pc,
    output logic [ISSUE_WIDTH-1:0]                slot_kill,
    output logic                                  exc_valid,
    output logic [31:0]                           exc_pc,
    output logic [31:0]                           exc_badv,
    output logic [5:0]                            exc_ecode,
    output logic [8:0]                            exc_esubcode,
    output logic                                  ertn_valid,
    output logic [NUM_STAGES-1:0]                 pause,
    output logic                                  int_pending,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]                           perf_stall_cycles,
    output logic [31:0]                           perf_flush_count,
`endif
    output logic                                  idle_active
);

    typedef enum logic [1:0] {ST_RUN, ST_IDLE, ST_WAKE} state_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_e                 state_q, state_d;
    logic [3:0]             flush_cnt_q, flush_cnt_d;
    logic [31:0]            flush_pc_q, flush_pc_d;
    logic [ISSUE_WIDTH-1:0] slot_kill_q, slot_kill_d;
    logic                   exc_valid_q, exc_valid_d;
    logic [31:0]            exc_pc_q, exc_pc_d;
    logic [31:0]            exc_badv_q, exc_badv_d;
    logic [5:0]             exc_ecode_q, exc_ecode_d;
    logic [8:0]             exc_esub_q, exc_esub_d;
    logic                   ertn_valid_q, ertn_valid_d;
    logic                   int_pending_q, int_pending_d;
    logic [31:0]            idle_pc_q, idle_pc_d;

    logic                   accept;
    logic                   found;
    logic                   trig_exc, trig_ertn, trig_idle;
    logic                   wake_fire, any_trig;
    logic                   ipe_src;
    logic [NUM_EXC_SRC-1:0] src_exc;
    logic [31:0]            sel_pc, sel_badv;
    logic [5:0]             sel_ecode;
    logic [8:0]             sel_esub;
    logic [NUM_STAGES-1:0]  pause_v;
    logic                   seen;

    assign accept        = (state_q == ST_RUN) && (flush_cnt_q == 4'd0);
    assign wake_fire     = (state_q == ST_WAKE);
    assign any_trig      = trig_exc | trig_ertn | wake_fire;
    assign int_pending_d = csr_ie & (|(csr_lie & csr_is));

    // Oldest slot with an event wins; every younger slot is killed behind it.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found       = 1'b0;
        trig_exc    = 1'b0;
        trig_ertn   = 1'b0;
        trig_idle   = 1'b0;
        ipe_src     = 1'b0;
        src_exc     = '0;
        sel_pc      = '0;
        sel_badv    = '0;
        sel_ecode   = '0;
        sel_esub    = '0;
        slot_kill_d = '0;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            if (found) begin
                slot_kill_d[s] = 1'b1;
            end else if (accept && commit_valid[s]) begin
                src_exc = commit_exc[s*NUM_EXC_SRC +: NUM_EXC_SRC];
                if ((|src_exc) || (s == 0 && int_pending_q)) begin
                    found          = 1'b1;
                    trig_exc       = 1'b1;
                    slot_kill_d[s] = 1'b1;
                    sel_pc         = commit_pc[s*32 +: 32];
                    sel_badv       = commit_badv[s*32 +: 32];
                    for (int j = 0; j < NUM_EXC_SRC; j++) begin
                        if (src_exc[j]) begin
                            sel_ecode = commit_cause[(s*NUM_EXC_SRC+j)*15+9 +: 6];
                            sel_esub  = commit_cause[(s*NUM_EXC_SRC+j)*15 +: 9];
                            ipe_src   = (j == 2);
                        end
                    end
                    if (ipe_src && commit_priv[s] && csr_plv != 2'd0) begin
                        sel_ecode = 6'h0E;
                        sel_esub  = 9'd0;
                    end
                    if (s == 0 && int_pending_q) begin
                        sel_ecode = 6'h00;
                        sel_esub  = 9'd0;
                    end
                end else if (commit_ertn[s]) begin
                    found     = 1'b1;
                    trig_ertn = 1'b1;
                end else if (commit_idle[s]) begin
                    found     = 1'b1;
                    trig_idle = 1'b1;
                    sel_pc    = commit_pc[s*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_pc_d   = flush_pc_q;
        exc_pc_d     = exc_pc_q;
        exc_badv_d   = exc_badv_q;
        exc_ecode_d  = exc_ecode_q;
        exc_esub_d   = exc_esub_q;
        idle_pc_d    = idle_pc_q;
        exc_valid_d  = trig_exc | wake_fire;
        ertn_valid_d = trig_ertn;
        flush_cnt_d  = (flush_cnt_q != 4'd0) ? flush_cnt_q - 4'd1 : 4'd0;
        if (any_trig) flush_cnt_d = FLUSH_LOAD;

        if (trig_exc) begin
            flush_pc_d  = csr_eentry;
            exc_pc_d    = sel_pc;
            exc_badv_d  = sel_badv;
            exc_ecode_d = sel_ecode;
            exc_esub_d  = sel_esub;
        end else if (trig_ertn) begin
            flush_pc_d  = csr_era;
        end

        case (state_q)
            ST_RUN: begin
                if (trig_idle) begin
                    state_d   = ST_IDLE;
                    idle_pc_d = sel_pc + 32'd4;
                end
            end
            ST_IDLE: if (int_pending_q) state_d = ST_WAKE;
            ST_WAKE: begin
                state_d     = ST_RUN;
                flush_pc_d  = csr_eentry;
                exc_pc_d    = idle_pc_q;
                exc_badv_d  = '0;
                exc_ecode_d = '0;
                exc_esub_d  = '0;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= '0;
            flush_pc_q    <= '0;
            slot_kill_q   <= '0;
            exc_valid_q   <= 1'b0;
            exc_pc_q      <= '0;
            exc_badv_q    <= '0;
            exc_ecode_q   <= '0;
            exc_esub_q    <= '0;
            ertn_valid_q  <= 1'b0;
            int_pending_q <= 1'b0;
            idle_pc_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            flush_pc_q    <= flush_pc_d;
            slot_kill_q   <= slot_kill_d;
            exc_valid_q   <= exc_valid_d;
            exc_pc_q      <= exc_pc_d;
            exc_badv_q    <= exc_badv_d;
            exc_ecode_q   <= exc_ecode_d;
            exc_esub_q    <= exc_esub_d;
            ertn_valid_q  <= ertn_valid_d;
            int_pending_q <= int_pending_d;
            idle_pc_q     <= idle_pc_d;
        end
    end

    // Thermometer from the highest requesting stage down to the PC stage.
    always_comb begin
        seen    = 1'b0;
        pause_v = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            seen       = seen | pause_req[i];
            pause_v[i] = seen;
        end
        if (state_q == ST_IDLE) pause_v = {1'b0, {(NUM_STAGES-1){1'b1}}};
        if (flush) pause_v = '0;
    end

    // pause is combinational from pause_req, so it is gated to honour the all-zero reset state.
    assign pause        = rst_n ? pause_v : '0;
    assign flush        = (flush_cnt_q != 4'd0);
    assign flush_pc     = flush_pc_q;
    assign slot_kill    = slot_kill_q;
    assign exc_valid    = exc_valid_q;
    assign exc_pc       = exc_pc_q;
    assign exc_badv     = exc_badv_q;
    assign exc_ecode    = exc_ecode_q;
    assign exc_esubcode = exc_esub_q;
    assign ertn_valid   = ertn_valid_q;
    assign int_pending  = int_pending_q;
    assign idle_active  = (state_q == ST_IDLE);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (|pause)   perf_stall_q <= perf_stall_q + 32'd1;
            if (any_trig) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_multi.sv
// Self-checking bench for pipe_ctrl_multi (FLUSH_CYCLES=3): vector table with a
// scoreboard queue, plus sequences for interrupts, idle/wake, flush hold and reset.
module tb_pipe_ctrl_multi;

    localparam int NS = 8;
    localparam int IW = 2;
    localparam int NE = 6;

    localparam logic [31:0] PC0    = 32'h1C00_0010;
    localparam logic [31:0] PC1    = 32'h1C00_0014;
    localparam logic [31:0] BV0    = 32'h0000_BAD0;
    localparam logic [31:0] BV1    = 32'h0000_BAD1;
    localparam logic [31:0] EENTRY = 32'h1C00_8000;
    localparam logic [31:0] ERA    = 32'h1C00_0200;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NS-1:0]        pause_req;
    logic [IW-1:0]        commit_valid;
    logic [IW*32-1:0]     commit_pc;
    logic [IW*NE-1:0]     commit_exc;
    logic [IW*NE*15-1:0]  commit_cause;
    logic [IW*32-1:0]     commit_badv;
    logic [IW-1:0]        commit_priv, commit_ertn, commit_idle;
    logic [1:0]           csr_plv;
    logic                 csr_ie;
    logic [12:0]          csr_lie, csr_is;
    logic [31:0]          csr_era, csr_eentry;
    logic                 flush, exc_valid, ertn_valid, int_pending, idle_active;
    logic [31:0]          flush_pc, exc_pc, exc_badv;
    logic [IW-1:0]        slot_kill;
    logic [5:0]           exc_ecode;
    logic [8:0]           exc_esubcode;
    logic [NS-1:0]        pause;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]          perf_stall_cycles, perf_flush_count;
`endif

    pipe_ctrl_multi #(.NUM_STAGES(NS), .ISSUE_WIDTH(IW), .NUM_EXC_SRC(NE), .FLUSH_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .pause_req(pause_req),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_exc(commit_exc),
        .commit_cause(commit_cause), .commit_badv(commit_badv), .commit_priv(commit_priv),
        .commit_ertn(commit_ertn), .commit_idle(commit_idle),
        .csr_plv(csr_plv), .csr_ie(csr_ie), .csr_lie(csr_lie), .csr_is(csr_is),
        .csr_era(csr_era), .csr_eentry(csr_eentry),
        .flush(flush), .flush_pc(flush_pc), .slot_kill(slot_kill),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_badv(exc_badv),
        .exc_ecode(exc_ecode), .exc_esubcode(exc_esubcode), .ertn_valid(ertn_valid),
        .pause(pause), .int_pending(int_pending),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count),
`endif
        .idle_active(idle_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [5:0]  exc0, exc1;
        logic [1:0]  priv, ertn, plv;
        logic [7:0]  preq;
        logic        e_exc, e_ertn, e_flush;
        logic [5:0]  e_ecode;
        logic [8:0]  e_esub;
        logic [31:0] e_pc, e_badv, e_fpc;
        logic [1:0]  e_kill;
        logic [7:0]  e_pause;
    } vec_t;

    vec_t vecs[12];
    vec_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] valid, input logic [5:0] exc0, input logic [5:0] exc1,
                                input logic [1:0] priv, input logic [1:0] ertn, input logic [1:0] plv,
                                input logic [7:0] preq, input logic e_exc, input logic e_ertn,
                                input logic [5:0] e_ecode, input logic [8:0] e_esub,
                                input logic [31:0] e_pc, input logic [31:0] e_badv,
                                input logic [1:0] e_kill, input logic [31:0] e_fpc,
                                input logic [7:0] e_pause);
        vec_t v;
        v.valid = valid; v.exc0 = exc0; v.exc1 = exc1; v.priv = priv; v.ertn = ertn;
        v.plv = plv; v.preq = preq; v.e_exc = e_exc; v.e_ertn = e_ertn;
        v.e_flush = e_exc | e_ertn; v.e_ecode = e_ecode; v.e_esub = e_esub;
        v.e_pc = e_pc; v.e_badv = e_badv; v.e_kill = e_kill; v.e_fpc = e_fpc;
        v.e_pause = e_pause;
        return v;
    endfunction

    task automatic clear_commit();
        commit_valid = '0;
        commit_exc   = '0;
        commit_priv  = '0;
        commit_ertn  = '0;
        commit_idle  = '0;
    endtask

    task automatic wait_flush_clear();
        int n = 0;
        while (flush && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("flush_clear", {31'd0, flush}, 32'd0);
    endtask

    task automatic raise_int(input logic on);
        csr_ie  = on;
        csr_lie = 13'h1;
        csr_is  = 13'h1;
    endtask

    task automatic idle_wake(input logic [31:0] pc, input logic [31:0] exp_pc);
        int n;
        wait_flush_clear();
        commit_valid = 2'b01;
        commit_idle  = 2'b01;
        commit_pc[31:0] = pc;
        pause_req = 8'h80;
        @(negedge clk);
        check("idle_active", {31'd0, idle_active}, 32'd1);
        check("idle_pause", {24'd0, pause}, 32'h7F);
        check("idle_no_exc", {31'd0, exc_valid}, 32'd0);
        check("idle_no_flush", {31'd0, flush}, 32'd0);
        clear_commit();
        commit_valid = 2'b01;
        commit_exc   = 12'h001;
        @(negedge clk);
        check("idle_commit_ignored", {31'd0, exc_valid}, 32'd0);
        clear_commit();
        pause_req = '0;
        raise_int(1'b1);
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (exc_valid) break;
        end
        raise_int(1'b0);
        check("wake_exc_valid", {31'd0, exc_valid}, 32'd1);
        check("wake_exc_pc", exc_pc, exp_pc);
        check("wake_badv", exc_badv, 32'd0);
        check("wake_ecode", {26'd0, exc_ecode}, 32'd0);
        check("wake_flush", {31'd0, flush}, 32'd1);
        check("wake_flush_pc", flush_pc, EENTRY);
        check("wake_run", {31'd0, idle_active}, 32'd0);
        commit_pc[31:0] = PC0;
        wait_flush_clear();
    endtask

    initial begin
        vec_t v;
        vec_t e;
        int   fl;

        rst_n = 1'b0;
        pause_req = '0;
        clear_commit();
        commit_pc   = {PC1, PC0};
        commit_badv = {BV1, BV0};
        csr_plv = 2'd0; csr_ie = 1'b0; csr_lie = '0; csr_is = '0;
        csr_era = ERA; csr_eentry = EENTRY;
        for (int s = 0; s < IW; s++)
            for (int j = 0; j < NE; j++)
                commit_cause[(s*NE+j)*15 +: 15] = {6'(16 + s*8 + j), 9'(256 + s*16 + j)};

        vecs[0]  = mk(2'b11, 6'b001001, 6'b000000, 2'b00, 2'b00, 2'd0, 8'h04, 1, 0, 6'h13, 9'h103, PC0, BV0, 2'b11, EENTRY, 8'h00);
        vecs[1]  = mk(2'b11, 6'b000000, 6'b000010, 2'b00, 2'b00, 2'd0, 8'h04, 1, 0, 6'h19, 9'h111, PC1, BV1, 2'b10, EENTRY, 8'h00);
        vecs[2]  = mk(2'b11, 6'b000100, 6'b000000, 2'b01, 2'b00, 2'd3, 8'h04, 1, 0, 6'h0E, 9'h000, PC0, BV0, 2'b11, EENTRY, 8'h00);
        vecs[3]  = mk(2'b11, 6'b000100, 6'b000000, 2'b01, 2'b00, 2'd0, 8'h04, 1, 0, 6'h12, 9'h102, PC0, BV0, 2'b11, EENTRY, 8'h00);
        vecs[4]  = mk(2'b11, 6'b000100, 6'b000000, 2'b00, 2'b00, 2'd3, 8'h04, 1, 0, 6'h12, 9'h102, PC0, BV0, 2'b11, EENTRY, 8'h00);
        vecs[5]  = mk(2'b11, 6'b100110, 6'b000000, 2'b01, 2'b00, 2'd3, 8'h04, 1, 0, 6'h15, 9'h105, PC0, BV0, 2'b11, EENTRY, 8'h00);
        vecs[6]  = mk(2'b11, 6'b000000, 6'b000000, 2'b00, 2'b01, 2'd0, 8'h04, 0, 1, 6'h00, 9'h000, 32'd0, 32'd0, 2'b10, ERA, 8'h00);
        vecs[7]  = mk(2'b11, 6'b000001, 6'b000000, 2'b00, 2'b10, 2'd0, 8'h04, 1, 0, 6'h10, 9'h100, PC0, BV0, 2'b11, EENTRY, 8'h00);
        vecs[8]  = mk(2'b11, 6'b000000, 6'b000001, 2'b00, 2'b01, 2'd0, 8'h04, 0, 1, 6'h00, 9'h000, 32'd0, 32'd0, 2'b10, ERA, 8'h00);
        vecs[9]  = mk(2'b11, 6'b000000, 6'b000000, 2'b00, 2'b00, 2'd0, 8'h14, 0, 0, 6'h00, 9'h000, 32'd0, 32'd0, 2'b00, 32'd0, 8'h1F);
        vecs[10] = mk(2'b00, 6'b111111, 6'b111111, 2'b00, 2'b00, 2'd0, 8'h80, 0, 0, 6'h00, 9'h000, 32'd0, 32'd0, 2'b00, 32'd0, 8'hFF);
        vecs[11] = mk(2'b10, 6'b111111, 6'b010000, 2'b00, 2'b00, 2'd0, 8'h04, 1, 0, 6'h1C, 9'h114, PC1, BV1, 2'b10, EENTRY, 8'h00);

        repeat (3) @(negedge clk);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
        check("rst_pause", {24'd0, pause}, 32'd0);
        check("rst_idle", {31'd0, idle_active}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            wait_flush_clear();
            v = vecs[i];
            commit_valid = v.valid;
            commit_exc   = {v.exc1, v.exc0};
            commit_priv  = v.priv;
            commit_ertn  = v.ertn;
            csr_plv      = v.plv;
            pause_req    = v.preq;
            sb_q.push_back(v);
            @(negedge clk);
            check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check($sformatf("v%0d_exc_valid", i), {31'd0, exc_valid}, {31'd0, e.e_exc});
                check($sformatf("v%0d_ertn_valid", i), {31'd0, ertn_valid}, {31'd0, e.e_ertn});
                check($sformatf("v%0d_slot_kill", i), {30'd0, slot_kill}, {30'd0, e.e_kill});
                check($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, e.e_flush});
                check($sformatf("v%0d_pause", i), {24'd0, pause}, {24'd0, e.e_pause});
                if (e.e_exc) begin
                    check($sformatf("v%0d_ecode", i), {26'd0, exc_ecode}, {26'd0, e.e_ecode});
                    check($sformatf("v%0d_esub", i), {23'd0, exc_esubcode}, {23'd0, e.e_esub});
                    check($sformatf("v%0d_exc_pc", i), exc_pc, e.e_pc);
                    check($sformatf("v%0d_badv", i), exc_badv, e.e_badv);
                end
                if (e.e_flush) check($sformatf("v%0d_flush_pc", i), flush_pc, e.e_fpc);
            end
            clear_commit();
            pause_req = '0;
            csr_plv   = 2'd0;
        end

        // Interrupt injection outranks a slot-0 ertn.
        wait_flush_clear();
        raise_int(1'b1);
        #1;
        check("int_latency", {31'd0, int_pending}, 32'd0);
        @(negedge clk);
        check("int_pending", {31'd0, int_pending}, 32'd1);
        commit_valid = 2'b11;
        commit_ertn  = 2'b01;
        @(negedge clk);
        check("int_exc_valid", {31'd0, exc_valid}, 32'd1);
        check("int_ecode", {26'd0, exc_ecode}, 32'd0);
        check("int_esub", {23'd0, exc_esubcode}, 32'd0);
        check("int_exc_pc", exc_pc, PC0);
        check("int_no_ertn", {31'd0, ertn_valid}, 32'd0);
        check("int_kill", {30'd0, slot_kill}, 32'd3);
        clear_commit();
        raise_int(1'b0);

        idle_wake(32'h1C00_0100, 32'h1C00_0104);
        idle_wake(32'hFFFF_FFFC, 32'h0000_0000);

        // Three-cycle ertn flush hold with a commit arriving inside the window.
        wait_flush_clear();
        pause_req    = 8'hFF;
        commit_valid = 2'b01;
        commit_ertn  = 2'b01;
        @(negedge clk);
        fl = flush ? 1 : 0;
        check("hold_ertn_valid", {31'd0, ertn_valid}, 32'd1);
        check("hold_flush_pc", flush_pc, ERA);
        check("hold_pause", {24'd0, pause}, 32'd0);
        clear_commit();
        commit_valid = 2'b01;
        commit_exc   = 12'h001;
        @(negedge clk);
        if (flush) fl++;
        check("hold_commit_ignored", {31'd0, exc_valid}, 32'd0);
        clear_commit();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!flush) break;
            fl++;
        end
        check("hold_length", fl, 32'd3);
        check("hold_pause_after", {24'd0, pause}, 32'hFF);

        // Asynchronous reset in the middle of a flush and of IDLE.
        pause_req    = 8'h0F;
        commit_valid = 2'b01;
        commit_exc   = 12'h001;
        @(negedge clk);
        clear_commit();
        check("pre_rst_flush", {31'd0, flush}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_flush", {31'd0, flush}, 32'd0);
        check("midrst_exc_valid", {31'd0, exc_valid}, 32'd0);
        check("midrst_kill", {30'd0, slot_kill}, 32'd0);
        check("midrst_exc_pc", exc_pc, 32'd0);
        check("midrst_flush_pc", flush_pc, 32'd0);
        check("midrst_pause", {24'd0, pause}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pause_req    = '0;
        commit_valid = 2'b01;
        commit_idle  = 2'b01;
        @(negedge clk);
        clear_commit();
        check("pre_rst_idle", {31'd0, idle_active}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_idle", {31'd0, idle_active}, 32'd0);
        check("midrst_idle_pause", {24'd0, pause}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
